// File: rtl/ula_sequencial_if.sv
// Handshake and data bus between the control unit (master) and the sequential ALU (slave).
interface ula_sequencial_if #(
    parameter int W = 16
);
    logic         processar;
    logic [3:0]   op;
    logic [W-1:0] ETp1;
    logic [W-1:0] ETp2;
    logic [W-1:0] Data;
    logic [W-1:0] Data_hi;
    logic         concluido;
    logic         ocupado;
    logic [3:0]   flags;
    logic         erro;

    modport master (
        output processar, op, ETp1, ETp2,
        input  Data, Data_hi, concluido, ocupado, flags, erro
    );

    modport slave (
        input  processar, op, ETp1, ETp2,
        output Data, Data_hi, concluido, ocupado, flags, erro
    );
endinterface

// File: rtl/ula_sequencial.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add multiply and
// restoring divide, double-width result, {Z,N,C,V} flags and an error output.
module ula_sequencial #(
    parameter int Tamanho_Da_Palavra = 16
) (
    input  logic             clk,
    input  logic             reset,
    ula_sequencial_if.slave  bus
);
    localparam int W  = Tamanho_Da_Palavra;
    localparam int CW = $clog2(W);

    localparam logic [3:0] OP_SOMA = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_E    = 4'd4;
    localparam logic [3:0] OP_NE   = 4'd5;
    localparam logic [3:0] OP_OU   = 4'd6;
    localparam logic [3:0] OP_XOU  = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_NAO  = 4'd9;

    typedef enum logic [1:0] {ESPERA, EXECUTANDO, SAIDA} estado_t;

    estado_t        r_estado, w_prox;
    logic [3:0]     r_op;
    logic [W-1:0]   r_a, r_b;
    logic [W-1:0]   r_hi, r_lo;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_data, r_data_hi;
    logic [3:0]     r_flags;
    logic           r_erro, r_concluido, r_ocupado;

    logic           w_captura, w_iterar, w_saida;
    logic [W:0]     w_soma, w_dif, w_msum, w_drem;
    logic [W-1:0]   w_dsub;
    logic           w_dge;
    logic [W-1:0]   w_data, w_data_hi, w_zn;
    logic           w_z, w_n, w_c, w_v, w_erro;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_estado <= ESPERA;
        else       r_estado <= w_prox;
    end

    always_comb begin
        w_prox    = r_estado;
        w_captura = 1'b0;
        w_iterar  = 1'b0;
        w_saida   = 1'b0;
        case (r_estado)
            ESPERA: begin
                if (bus.processar) begin
                    w_captura = 1'b1;
                    w_prox    = EXECUTANDO;
                end
            end
            EXECUTANDO: begin
                // Divide by zero skips the iterations and reports in one cycle.
                if (r_op == OP_MUL || (r_op == OP_DIV && r_b != '0)) begin
                    w_iterar = 1'b1;
                    if (r_cnt == CW'(W - 1)) w_prox = SAIDA;
                end else begin
                    w_prox = SAIDA;
                end
            end
            SAIDA: begin
                w_saida = 1'b1;
                w_prox  = ESPERA;
            end
            default: w_prox = ESPERA;
        endcase
    end

    // ---------------- iteration datapath ----------------
    // Multiply: {r_hi, r_lo} shifts right, r_lo starts as B and drains into the low product.
    assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    // Divide: r_lo starts as A and fills with quotient bits, r_hi is the partial remainder.
    assign w_drem = {r_hi, r_lo[W-1]};
    assign w_dge  = (w_drem >= {1'b0, r_b});
    assign w_dsub = w_drem[W-1:0] - r_b;

    assign w_soma = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif  = {1'b0, r_a} - {1'b0, r_b};

    // ---------------- result selection ----------------
    always_comb begin
        w_data    = r_data;
        w_data_hi = r_data_hi;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_erro    = 1'b0;
        case (r_op)
            OP_SOMA: begin
                w_data    = w_soma[W-1:0];
                w_data_hi = '0;
                w_c       = w_soma[W];
                w_v       = (r_a[W-1] == r_b[W-1]) && (w_soma[W-1] != r_a[W-1]);
            end
            OP_SUB: begin
                w_data    = w_dif[W-1:0];
                w_data_hi = '0;
                w_c       = w_dif[W];
                w_v       = (r_a[W-1] != r_b[W-1]) && (w_dif[W-1] != r_a[W-1]);
            end
            OP_MUL: begin
                w_data    = r_lo;
                w_data_hi = r_hi;
                w_c       = (r_hi != '0);
                w_v       = (r_hi != '0);
            end
            OP_DIV: begin
                if (r_b == '0) begin
                    w_data    = '1;
                    w_data_hi = r_a;
                    w_erro    = 1'b1;
                end else begin
                    w_data    = r_lo;
                    w_data_hi = r_hi;
                end
            end
            OP_E:   begin w_data = r_a & r_b;    w_data_hi = '0; end
            OP_NE:  begin w_data = ~(r_a & r_b); w_data_hi = '0; end
            OP_OU:  begin w_data = r_a | r_b;    w_data_hi = '0; end
            OP_XOU: begin w_data = r_a ^ r_b;    w_data_hi = '0; end
            OP_CMP: begin
                w_c = w_dif[W];
                w_v = (r_a[W-1] != r_b[W-1]) && (w_dif[W-1] != r_a[W-1]);
            end
            OP_NAO: begin w_data = ~r_a; w_data_hi = '0; end
            default: begin
                w_data    = '0;
                w_data_hi = '0;
                w_erro    = 1'b1;
            end
        endcase
        // Compare leaves the data outputs alone, so Z/N come from the difference.
        w_zn = (r_op == OP_CMP) ? w_dif[W-1:0] : w_data;
        w_z  = (w_zn == '0) && !(r_op == OP_MUL && r_hi != '0);
        w_n  = w_zn[W-1];
        if (r_op > OP_NAO) begin
            w_z = 1'b0;
            w_n = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_data_hi   <= '0;
            r_flags     <= '0;
            r_erro      <= 1'b0;
            r_concluido <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_concluido <= w_saida;
            r_ocupado   <= w_captura || (r_estado != ESPERA);
            if (w_captura) begin
                r_op  <= bus.op;
                r_a   <= bus.ETp1;
                r_b   <= bus.ETp2;
                r_cnt <= '0;
                r_hi  <= '0;
                r_lo  <= (bus.op == OP_DIV) ? bus.ETp1 : bus.ETp2;
            end else if (w_iterar) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_op == OP_MUL) begin
                    r_hi <= w_msum[W:1];
                    r_lo <= {w_msum[0], r_lo[W-1:1]};
                end else begin
                    r_hi <= w_dge ? w_dsub : w_drem[W-1:0];
                    r_lo <= {r_lo[W-2:0], w_dge};
                end
            end
            if (w_saida) begin
                r_cnt     <= '0;
                r_data    <= w_data;
                r_data_hi <= w_data_hi;
                r_flags   <= {w_z, w_n, w_c, w_v};
                r_erro    <= w_erro;
            end
        end
    end

    assign bus.Data      = r_data;
    assign bus.Data_hi   = r_data_hi;
    assign bus.flags     = r_flags;
    assign bus.erro      = r_erro;
    assign bus.concluido = r_concluido;
    assign bus.ocupado   = r_ocupado;
endmodule

// File: tb/tb_ula_sequencial.sv
// Scenario tasks plus a randomized run against an arithmetic reference model (W=16),
// with a W=8 instance for the narrow multiply case.
module tb_ula_sequencial;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ula_sequencial_if #(.W(16)) ifc16();
    ula_sequencial_if #(.W(8))  ifc8();

    ula_sequencial #(.Tamanho_Da_Palavra(16)) dut16 (.clk(clk), .reset(reset), .bus(ifc16));
    ula_sequencial #(.Tamanho_Da_Palavra(8))  dut8  (.clk(clk), .reset(reset), .bus(ifc8));

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_data, m_hi;
    logic [3:0]  m_flags;
    logic        m_erro;
    int          m_lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what a W=16 result should be, from plain integer arithmetic.
    task automatic model_apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, r;
        logic [31:0] p;
        logic z, n, c, v;
        ua = a; ub = b;
        sa = int'($signed(a)); sb = int'($signed(b));
        r = 0; p = 0; c = 1'b0; v = 1'b0;
        m_erro = 1'b0;
        m_lat  = 2;
        case (op)
            4'd0: begin r = ua + ub; m_data = r[15:0]; m_hi = 0; c = (r > 65535);
                        v = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1, 4'd8: begin r = ua - ub; c = (ua < ub);
                        v = (sa - sb > 32767) || (sa - sb < -32768);
                        if (op == 4'd1) begin m_data = r[15:0]; m_hi = 0; end end
            4'd2: begin p = {16'h0, a} * {16'h0, b}; m_data = p[15:0]; m_hi = p[31:16];
                        c = (m_hi != 0); v = c; m_lat = 17; end
            4'd3: begin
                if (b == 0) begin m_data = 16'hFFFF; m_hi = a; m_erro = 1'b1; end
                else begin m_data = a / b; m_hi = a % b; m_lat = 17; end
            end
            4'd4: begin m_data = a & b;    m_hi = 0; end
            4'd5: begin m_data = ~(a & b); m_hi = 0; end
            4'd6: begin m_data = a | b;    m_hi = 0; end
            4'd7: begin m_data = a ^ b;    m_hi = 0; end
            4'd9: begin m_data = ~a;       m_hi = 0; end
            default: begin m_data = 0; m_hi = 0; m_erro = 1'b1; end
        endcase
        if (op == 4'd8)      begin z = (r[15:0] == 16'h0); n = r[15]; end
        else if (op == 4'd2) begin z = (p == 0); n = m_data[15]; end
        else if (op > 4'd9)  begin z = 1'b0; n = 1'b0; end
        else                 begin z = (m_data == 0); n = m_data[15]; end
        m_flags = {z, n, c, v};
    endtask

    // Start one op on the W=16 DUT; returns edges from the sampling edge to concluido (-1 on timeout).
    task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int lat);
        ifc16.processar = 1'b1; ifc16.op = op; ifc16.ETp1 = a; ifc16.ETp2 = b;
        tick();
        ifc16.processar = 1'b0;
        ifc16.op   = 4'($urandom);
        ifc16.ETp1 = 16'($urandom);
        ifc16.ETp2 = 16'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ifc16.concluido === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc16.processar = 1'b1; ifc16.op = 4'd0; ifc16.ETp1 = 16'h1111; ifc16.ETp2 = 16'h2222;
        tick(); tick();
        n_checks++;
        if ({ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro, ifc16.concluido, ifc16.ocupado} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_state got D=%h H=%h F=%b E=%b C=%b O=%b exp all zero",
                     ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro, ifc16.concluido, ifc16.ocupado);
        end
        reset = 1'b0;
        ifc16.processar = 1'b0;
        tick();
        n_checks++;
        if (ifc16.ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority ocupado got=%b exp=0", ifc16.ocupado);
        end
        m_data = 0; m_hi = 0;
    endtask

    task automatic test_soma();
        int lat;
        model_apply(4'd0, 16'h7FFF, 16'h0001);
        run16(4'd0, 16'h7FFF, 16'h0001, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL soma_latency got=%0d exp=2", lat); end
        n_checks++;
        if ({ifc16.Data, ifc16.flags, ifc16.erro} !== {16'h8000, 4'b0101, 1'b0}) begin
            n_fail++;
            $display("FAIL soma_result got D=%h F=%b E=%b exp D=8000 F=0101 E=0", ifc16.Data, ifc16.flags, ifc16.erro);
        end
        tick();
        n_checks++;
        if (ifc16.concluido !== 1'b0) begin n_fail++; $display("FAIL soma_pulse_width concluido got=%b exp=0", ifc16.concluido); end
    endtask

    task automatic test_sub_cmp();
        int lat;
        model_apply(4'd1, 16'h0003, 16'h0005);
        run16(4'd1, 16'h0003, 16'h0005, lat);
        n_checks++;
        if ({ifc16.Data, ifc16.flags, lat} !== {16'hFFFE, 4'b0110, 32'd2}) begin
            n_fail++;
            $display("FAIL sub_result got D=%h F=%b L=%0d exp D=fffe F=0110 L=2", ifc16.Data, ifc16.flags, lat);
        end
        model_apply(4'd8, 16'h0005, 16'h0005);
        run16(4'd8, 16'h0005, 16'h0005, lat);
        n_checks++;
        if ({ifc16.Data, ifc16.flags, ifc16.erro} !== {16'hFFFE, 4'b1000, 1'b0}) begin
            n_fail++;
            $display("FAIL cmp_result got D=%h F=%b E=%b exp D=fffe F=1000 E=0", ifc16.Data, ifc16.flags, ifc16.erro);
        end
    endtask

    task automatic test_mul();
        int lat;
        model_apply(4'd2, 16'h1234, 16'h0100);
        run16(4'd2, 16'h1234, 16'h0100, lat);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL mul_latency got=%0d exp=17", lat); end
        n_checks++;
        if ({ifc16.Data, ifc16.Data_hi, ifc16.flags} !== {16'h3400, 16'h0012, 4'b0011}) begin
            n_fail++;
            $display("FAIL mul_result got D=%h H=%h F=%b exp D=3400 H=0012 F=0011", ifc16.Data, ifc16.Data_hi, ifc16.flags);
        end
    endtask

    task automatic test_mul_w8();
        int lat;
        ifc8.processar = 1'b1; ifc8.op = 4'd2; ifc8.ETp1 = 8'hFF; ifc8.ETp2 = 8'hFF;
        tick();
        ifc8.processar = 1'b0; ifc8.ETp1 = 8'h00; ifc8.ETp2 = 8'h00;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ifc8.concluido === 1'b1) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL mul8_latency got=%0d exp=9", lat); end
        n_checks++;
        if ({ifc8.Data, ifc8.Data_hi, ifc8.flags} !== {8'h01, 8'hFE, 4'b0011}) begin
            n_fail++;
            $display("FAIL mul8_result got D=%h H=%h F=%b exp D=01 H=fe F=0011", ifc8.Data, ifc8.Data_hi, ifc8.flags);
        end
    endtask

    task automatic test_div();
        int lat;
        model_apply(4'd3, 16'd100, 16'd7);
        run16(4'd3, 16'd100, 16'd7, lat);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL div_latency got=%0d exp=17", lat); end
        n_checks++;
        if ({ifc16.Data, ifc16.Data_hi, ifc16.erro} !== {16'd14, 16'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL div_result got Q=%0d R=%0d E=%b exp Q=14 R=2 E=0", ifc16.Data, ifc16.Data_hi, ifc16.erro);
        end
        model_apply(4'd3, 16'd5, 16'd0);
        run16(4'd3, 16'd5, 16'd0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL div0_latency got=%0d exp=2", lat); end
        n_checks++;
        if ({ifc16.Data, ifc16.Data_hi, ifc16.erro} !== {16'hFFFF, 16'h0005, 1'b1}) begin
            n_fail++;
            $display("FAIL div0_result got D=%h H=%h E=%b exp D=ffff H=0005 E=1", ifc16.Data, ifc16.Data_hi, ifc16.erro);
        end
    endtask

    task automatic test_reset_mid();
        int pulses, lat;
        ifc16.processar = 1'b1; ifc16.op = 4'd2; ifc16.ETp1 = 16'h00FF; ifc16.ETp2 = 16'h0101;
        tick();
        ifc16.processar = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({ifc16.ocupado, ifc16.concluido, ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_mid_state got O=%b C=%b D=%h H=%h F=%b E=%b exp all zero",
                     ifc16.ocupado, ifc16.concluido, ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro);
        end
        reset = 1'b0;
        m_data = 0; m_hi = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc16.concluido === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_no_concluido got=%0d exp=0", pulses); end
        model_apply(4'd0, 16'd2, 16'd3);
        run16(4'd0, 16'd2, 16'd3, lat);
        n_checks++;
        if ({ifc16.Data, lat} !== {16'd5, 32'd2}) begin
            n_fail++;
            $display("FAIL after_reset_soma got D=%0d L=%0d exp D=5 L=2", ifc16.Data, lat);
        end
    endtask

    task automatic test_illegal();
        int lat;
        model_apply(4'd12, 16'h1234, 16'h5678);
        run16(4'd12, 16'h1234, 16'h5678, lat);
        n_checks++;
        if ({ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro, lat} !== {16'h0, 16'h0, 4'b0000, 1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL illegal_op got D=%h H=%h F=%b E=%b L=%0d exp D=0 H=0 F=0000 E=1 L=2",
                     ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro, lat);
        end
    endtask

    task automatic test_busy_ignore();
        int pulses;
        model_apply(4'd2, 16'h0003, 16'h0004);
        ifc16.processar = 1'b1; ifc16.op = 4'd2; ifc16.ETp1 = 16'h0003; ifc16.ETp2 = 16'h0004;
        tick();
        ifc16.processar = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        ifc16.processar = 1'b1; ifc16.op = 4'd0;
        tick();
        ifc16.processar = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ifc16.concluido === 1'b1) pulses++;
        end
        n_checks++;
        if ({pulses, ifc16.Data} !== {32'd1, m_data}) begin
            n_fail++;
            $display("FAIL busy_ignore got pulses=%0d D=%h exp pulses=1 D=%h", pulses, ifc16.Data, m_data);
        end
    endtask

    task automatic test_back_to_back();
        int t_pulse[3];
        int k;
        t_pulse = '{-1, -1, -1};
        k = 0;
        model_apply(4'd0, 16'h0010, 16'h0020);
        ifc16.processar = 1'b1; ifc16.op = 4'd0; ifc16.ETp1 = 16'h0010; ifc16.ETp2 = 16'h0020;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (ifc16.concluido === 1'b1) begin
                if (k < 3) t_pulse[k] = t;
                k++;
            end
            if (t == 7) ifc16.processar = 1'b0;
        end
        n_checks++;
        if ({k, t_pulse[0], t_pulse[1], t_pulse[2]} !== {32'd3, 32'd3, 32'd6, 32'd9}) begin
            n_fail++;
            $display("FAIL back_to_back got n=%0d at %0d,%0d,%0d exp n=3 at 3,6,9", k, t_pulse[0], t_pulse[1], t_pulse[2]);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        logic [3:0] op;
        logic [15:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            model_apply(op, a, b);
            run16(op, a, b, lat);
            n_checks++;
            if ({ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro} !== {m_data, m_hi, m_flags, m_erro}) begin
                n_fail++;
                $display("FAIL rand_result op=%0d a=%h b=%h got D=%h H=%h F=%b E=%b exp D=%h H=%h F=%b E=%b",
                         op, a, b, ifc16.Data, ifc16.Data_hi, ifc16.flags, ifc16.erro, m_data, m_hi, m_flags, m_erro);
            end
            n_checks++;
            if (lat !== m_lat) begin
                n_fail++;
                $display("FAIL rand_latency op=%0d b=%h got=%0d exp=%0d", op, b, lat, m_lat);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ifc16.processar = 1'b0; ifc16.op = 4'd0; ifc16.ETp1 = 16'h0; ifc16.ETp2 = 16'h0;
        ifc8.processar  = 1'b0; ifc8.op  = 4'd0; ifc8.ETp1  = 8'h0;  ifc8.ETp2  = 8'h0;
        m_data = 0; m_hi = 0; m_flags = 0; m_erro = 0; m_lat = 0;
        test_reset();
        test_soma();
        test_sub_cmp();
        test_mul();
        test_mul_w8();
        test_div();
        test_reset_mid();
        test_illegal();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
